// File: rtl/median_pkg.sv
// Shared types and helpers for the median filter datapath.
package median_pkg;

  localparam int SAMPLE_W = 10;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic int sort_latency(input int n);
    return n + 1;
  endfunction

  function automatic int median_idx(input int n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/median_out_fifo.sv
// First-word-fall-through FIFO holding finished medians.
module median_out_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wr_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       rd_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             pop;

  assign valid_o = (count_o != '0);
  assign pop     = rd_i & valid_o;
  assign data_o  = valid_o ? mem[rptr] : '0;

  always_ff @(posedge clk_i) begin
    if (wr_i)
      mem[wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
    end else begin
      if (wr_i)
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (pop)
        rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      if (wr_i && !pop)
        count_o <= count_o + 1'b1;
      else if (!wr_i && pop)
        count_o <= count_o - 1'b1;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(wr_i && (count_o == FULL) && !pop));

endmodule

// File: rtl/sorting_network.sv
// Fixed-latency odd-even transposition sorter, ascending order.
module sorting_network #(
  parameter int NUMBER_WIDTH   = 10,
  parameter int NUMBERS_AMOUNT = 9
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic [NUMBERS_AMOUNT*NUMBER_WIDTH-1:0] data_i,
  output logic valid_o,
  output logic [NUMBERS_AMOUNT*NUMBER_WIDTH-1:0] data_o
);

  localparam int N = NUMBERS_AMOUNT;
  localparam int W = NUMBER_WIDTH;

  logic [W-1:0] st  [N+1][N];
  logic [W-1:0] nxt [N][N];
  logic [N:0]   vld;

  function automatic int pidx(input int s, input int i);
    if ((i + s) % 2 == 0)
      return (i + 1 < N) ? i + 1 : i;
    return (i > 0) ? i - 1 : i;
  endfunction

  function automatic logic [W-1:0] pick(
    input logic          lo,
    input logic [W-1:0]  a,
    input logic [W-1:0]  b
  );
    if (lo)
      return (b < a) ? b : a;
    return (b > a) ? b : a;
  endfunction

  always_comb begin
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < N; i++) begin
        nxt[s][i] = pick((i + s) % 2 == 0,
                         st[s][i], st[s][pidx(s, i)]);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld <= '0;
      for (int s = 0; s <= N; s++)
        for (int i = 0; i < N; i++)
          st[s][i] <= '0;
    end else begin
      vld <= {vld[N-1:0], valid_i};
      for (int i = 0; i < N; i++)
        st[0][i] <= data_i[i*W +: W];
      for (int s = 0; s < N; s++)
        for (int i = 0; i < N; i++)
          st[s+1][i] <= nxt[s][i];
    end
  end

  assign valid_o = vld[N];

  for (genvar i = 0; i < N; i++) begin : g_out
    assign data_o[i*W +: W] = st[N][i];
  end

endmodule

// File: rtl/median_window_ctrl.sv
// Sliding-window median stage: window register, sorter, credit-gated FIFO.
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int WINDOW     = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  snk_valid_i,
  output logic                  snk_ready_o,
  input  logic [DATA_WIDTH-1:0] snk_data_i,
  output logic                  src_valid_o,
  input  logic                  src_ready_i,
  output logic [DATA_WIDTH-1:0] src_data_o
);

  localparam int DW  = DATA_WIDTH;
  localparam int FW  = $clog2(WINDOW + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int MID = median_idx(WINDOW);
  localparam logic [FW-1:0] FILL_MAX  = FW'(WINDOW);
  localparam logic [FW-1:0] FILL_PROD = FW'(WINDOW - 1);
  localparam logic [CW-1:0] CRED_MAX  = CW'(FIFO_DEPTH);

  logic [DW-1:0]        win [WINDOW];
  logic [WINDOW*DW-1:0] win_flat;
  logic [WINDOW*DW-1:0] sorted_flat;
  logic [FW-1:0]        fill;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        fifo_count;
  logic                 issue;
  logic                 sort_valid;
  logic                 accept;
  logic                 producing;
  logic                 pop;

  assign snk_ready_o = ~flush_i &
    ((outstanding < CRED_MAX) | (fill < FILL_PROD));
  assign accept    = snk_valid_i & snk_ready_o;
  assign producing = accept & (fill >= FILL_PROD);
  assign pop       = src_valid_o & src_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill        <= '0;
      outstanding <= '0;
      issue       <= 1'b0;
      for (int i = 0; i < WINDOW; i++)
        win[i] <= '0;
    end else begin
      issue <= producing;
      if (producing && !pop)
        outstanding <= outstanding + 1'b1;
      else if (!producing && pop)
        outstanding <= outstanding - 1'b1;
      if (flush_i) begin
        fill <= '0;
        for (int i = 0; i < WINDOW; i++)
          win[i] <= '0;
      end else if (accept) begin
        win[0] <= snk_data_i;
        for (int i = 1; i < WINDOW; i++)
          win[i] <= win[i-1];
        if (fill < FILL_MAX)
          fill <= fill + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < WINDOW; i++) begin : g_flat
    assign win_flat[i*DW +: DW] = win[i];
  end

  sorting_network #(
    .NUMBER_WIDTH   (DW),
    .NUMBERS_AMOUNT (WINDOW)
  ) u_sort (
    .clk_i   (clk_i),
    .rst_i   (~rst_n_i),
    .valid_i (issue),
    .data_i  (win_flat),
    .valid_o (sort_valid),
    .data_o  (sorted_flat)
  );

  median_out_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_i    (sort_valid),
    .data_i  (sorted_flat[MID*DW +: DW]),
    .rd_i    (src_ready_i),
    .valid_o (src_valid_o),
    .data_o  (src_data_o),
    .count_o (fifo_count)
  );

  // Credits are taken at accept time, so the FIFO can never hold more.
  assert property (@(posedge clk_i) disable iff (!rst_n_i)
    fifo_count <= outstanding);

  for (genvar i = 0; i < WINDOW - 1; i++) begin : g_ord
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
      sort_valid |->
        (sorted_flat[i*DW +: DW] <= sorted_flat[(i+1)*DW +: DW]));
  end

endmodule

// File: tb/tb_median_window_ctrl.sv
// Scoreboard bench for median_window_ctrl at WINDOW=5, 8-bit, depth 8.
module tb_median_window_ctrl;

  localparam int DW  = 8;
  localparam int WIN = 5;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          snk_valid = 1'b0;
  logic          snk_ready;
  logic [DW-1:0] snk_data = '0;
  logic          src_valid;
  logic          src_ready = 1'b1;
  logic [DW-1:0] src_data;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int first_out = -1;
  logic [DW-1:0] exp_q[$];

  median_window_ctrl #(
    .DATA_WIDTH (DW),
    .WINDOW     (WIN),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .snk_valid_i (snk_valid),
    .snk_ready_o (snk_ready),
    .snk_data_i  (snk_data),
    .src_valid_o (src_valid),
    .src_ready_i (src_ready),
    .src_data_o  (src_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst_n && src_valid && src_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_median got %0d want none", src_data);
      end else begin
        e = exp_q.pop_front();
        if (src_data == e) passes++;
        else $display("FAIL median got %0d want %0d", src_data, e);
      end
      if (first_out < 0) first_out = cyc;
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s got %0d want %0d", name, got, want);
  endtask

  task automatic send(input logic [DW-1:0] d, output int acc_cyc);
    int t;
    t = 0;
    snk_valid = 1'b1;
    snk_data  = d;
    @(negedge clk);
    while (!snk_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      $display("FAIL send_timeout got busy want ready");
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    snk_valid = 1'b0;
  endtask

  task automatic flush_pulse();
    flush     = 1'b1;
    snk_valid = 1'b1;
    snk_data  = 8'd99;
    @(negedge clk);
    check("ready_in_flush", int'(snk_ready), 0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    snk_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      $display("FAIL drain_timeout got %0d left want 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_list(input logic [DW-1:0] v [], output int last);
    foreach (v[i]) send(v[i], last);
  endtask

  task automatic run_warmup();
    int acc5;
    int a;
    logic [DW-1:0] w [7];
    w = '{10, 50, 30, 20, 40, 60, 0};
    flush_pulse();
    src_ready = 1'b1;
    first_out = -1;
    exp_q.push_back(30);
    exp_q.push_back(40);
    exp_q.push_back(30);
    acc5 = 0;
    for (int i = 0; i < 7; i++) begin
      send(w[i], a);
      if (i == 4) acc5 = a;
    end
    wait_drain();
    check("warmup_latency", first_out - acc5, 7);
  endtask

  initial begin
    int a;
    int acc;
    logic r;
    logic [DW-1:0] seq [16];
    logic [DW-1:0] fl9 [];
    logic [DW-1:0] ext [];
    logic [DW-1:0] dup [];
    logic [DW-1:0] mix [];

    #1;
    check("reset_ready", int'(snk_ready), 1);
    check("reset_valid", int'(src_valid), 0);
    check("reset_data", int'(src_data), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ready", int'(snk_ready), 1);
      check("idle_valid", int'(src_valid), 0);
    end

    run_warmup();

    seq = '{5, 3, 9, 1, 7, 2, 8, 6, 4, 0, 11, 10,
            20, 21, 22, 23};
    flush_pulse();
    src_ready = 1'b0;
    foreach (seq[i]) if (i < 8) exp_q.push_back(8'd0);
    exp_q.delete();
    exp_q.push_back(5);
    exp_q.push_back(3);
    exp_q.push_back(7);
    exp_q.push_back(6);
    exp_q.push_back(6);
    exp_q.push_back(4);
    exp_q.push_back(6);
    exp_q.push_back(6);
    acc = 0;
    snk_valid = 1'b1;
    snk_data  = seq[0];
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      r = snk_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc++;
        snk_data = seq[acc];
      end
    end
    snk_valid = 1'b0;
    check("bp_accepted", acc, 12);
    @(negedge clk);
    check("bp_ready_low", int'(snk_ready), 0);
    check("bp_valid", int'(src_valid), 1);
    check("bp_head", int'(src_data), 5);
    @(negedge clk);
    check("bp_head_stable", int'(src_data), 5);
    src_ready = 1'b1;
    wait_drain();
    check("bp_ready_back", int'(snk_ready), 1);

    fl9 = '{60, 10, 90, 30, 70, 20, 80, 40, 50};
    ext = '{255, 0, 255, 0, 255};
    dup = '{7, 7, 7, 7, 7};
    mix = '{0, 1, 0, 1, 1};
    flush_pulse();
    exp_q.push_back(60);
    exp_q.push_back(30);
    exp_q.push_back(70);
    exp_q.push_back(40);
    exp_q.push_back(50);
    send_list(fl9, a);
    flush_pulse();
    exp_q.push_back(255);
    send_list(ext, a);
    wait_drain();
    flush_pulse();
    exp_q.push_back(7);
    send_list(dup, a);
    wait_drain();
    flush_pulse();
    exp_q.push_back(1);
    send_list(mix, a);
    wait_drain();

    flush_pulse();
    src_ready = 1'b0;
    send_list(fl9, a);
    repeat (12) @(negedge clk);
    check("prerst_valid", int'(src_valid), 1);
    send(8'd33, a);
    send(8'd44, a);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_drop", int'(src_valid), 0);
    check("rst_ready", int'(snk_ready), 1);
    check("rst_data", int'(src_data), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    exp_q.delete();
    src_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_quiet", int'(src_valid), 0);

    run_warmup();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
